// File: rtl/test_pkg.sv
// test_pkg: shared definitions for the demo CPU.
//   - opcode encoding and instruction field layout
//   - the fixed 16-word program ROM
//   - active-low seven-segment codes for digits 0-9, segments {a..g} = [6:0]
package test_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_LW  = 2'b01,
    OP_SW  = 2'b10,
    OP_J   = 2'b11
  } opcode_e;

  // Instruction byte fields; a jump reuses {rs, rt, low} as imm6.
  typedef struct packed {
    opcode_e    op;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [1:0] low;
  } instr_t;

  localparam int ROM_DEPTH  = 16;
  localparam int DMEM_DEPTH = 32;

  localparam logic [7:0] ROM [ROM_DEPTH] = '{
    8'h45,  // 0: LW  R1,[R0+1]
    8'h4B,  // 1: LW  R2,[R0+3]
    8'h1B,  // 2: ADD R3 = R1 + R2
    8'h1D,  // 3: ADD R1 = R1 + R3
    8'hFE,  // 4: J   -2  (back to 3)
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,  // 5..15: J -1 (park)
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF
  };

  localparam logic [6:0] SEG_CODE [10] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
    7'h24, 7'h20, 7'h0F, 7'h00, 7'h04
  };

  // Pattern for an out-of-range digit: all segments off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: BCD digit to active-low seven-segment pattern.
//   digit in  [3:0] : value 0-9 (10-15 blank the display)
//   seg   out [6:0] : segments {a,b,c,d,e,f,g}, 0 = lit
module seg7_decoder
  import test_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: assign a default before the conditional so every path drives seg;
    // otherwise synthesis infers a latch to hold the old value.
    seg = SEG_BLANK;
    if (digit < 4'd10) seg = SEG_CODE[digit];
  end

endmodule

// File: rtl/test_top.sv
// test_top: board-level demo CPU.
//   8-bit single-cycle machine, four registers, 16-word ROM program,
//   32-byte RAM with asynchronous read. The last ADD/LW result is latched
//   into a display register and shown as two decimal digits (mod 100).
//   clk   in      : system clock, all state updates on the rising edge
//   Reset in      : synchronous, active-high; restores PC, registers,
//                   display and RAM contents (RAM[i] = i)
//   Tens  out [6:0]: tens digit, active-low segments {a..g}
//   Ones  out [6:0]: ones digit, active-low segments {a..g}
module test_top
  import test_pkg::*;
(
  input  logic       clk,
  input  logic       Reset,
  output logic [6:0] Tens,
  output logic [6:0] Ones
);

  logic [3:0] pc;
  logic [7:0] regs [4];
  logic [7:0] dmem [DMEM_DEPTH];
  logic [7:0] disp;

  logic [7:0] instr;
  instr_t     ins;
  logic [7:0] rs_val;
  logic [7:0] rt_val;
  logic [7:0] sum;
  logic [4:0] addr;
  logic [7:0] load_val;

  assign instr    = ROM[pc];
  assign ins      = instr_t'(instr);
  assign rs_val   = regs[ins.rs];
  assign rt_val   = regs[ins.rt];
  assign sum      = rs_val + rt_val;
  // RAM address wraps modulo 32, so only the low five bits of the sum matter.
  assign addr     = rs_val[4:0] + {3'b000, ins.low};
  assign load_val = dmem[addr];

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register,
    // RAM word, PC and DISP sees the pre-edge values of the others.
    if (Reset) begin
      pc   <= '0;
      disp <= '0;
      for (int r = 0; r < 4; r++) regs[r] <= '0;
      // NOTE: the RAM has a defined power-on image, so it is reset word by
      // word; this keeps it in flops rather than a RAM macro, which is fine
      // at 32 bytes.
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= 8'(i);
    end else begin
      pc <= pc + 4'd1;
      unique case (ins.op)
        OP_ADD: begin
          regs[ins.low] <= sum;
          disp          <= sum;
        end
        OP_LW: begin
          regs[ins.rt] <= load_val;
          disp         <= load_val;
        end
        OP_SW: dmem[addr] <= rt_val;
        // Sign-extended imm6 modulo 16 is just its low four bits.
        OP_J:  pc <= pc + 4'd1 + instr[3:0];
      endcase
    end
  end

  logic [7:0] tens_bin;
  logic [7:0] ones_bin;

  assign tens_bin = (disp / 8'd10) % 8'd10;
  assign ones_bin = disp % 8'd10;

  seg7_decoder u_tens (.digit(tens_bin[3:0]), .seg(Tens));
  seg7_decoder u_ones (.digit(ones_bin[3:0]), .seg(Ones));

endmodule

// File: tb/tb_test_top.sv
// tb_test_top: directed, table-driven checks of the demo CPU display output.
module tb_test_top;

  logic       clk;
  logic       Reset;
  logic [6:0] Tens;
  logic [6:0] Ones;

  int checks   = 0;
  int failures = 0;
  int cur_edge = 0;  // rising edges since Reset was last released

  test_top dut (
    .clk  (clk),
    .Reset(Reset),
    .Tens (Tens),
    .Ones (Ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Segment codes for digits 0-9, written out independently of the design.
  logic [6:0] exp_seg [10];
  initial begin
    exp_seg[0] = 7'h01; exp_seg[1] = 7'h4F; exp_seg[2] = 7'h12;
    exp_seg[3] = 7'h06; exp_seg[4] = 7'h4C; exp_seg[5] = 7'h24;
    exp_seg[6] = 7'h20; exp_seg[7] = 7'h0F; exp_seg[8] = 7'h00;
    exp_seg[9] = 7'h04;
  end

  typedef struct {
    int    edge_no;   // edges after reset release
    int    shown;     // expected two-digit display value
    string name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_disp(input string name, input int value);
    check({name, ".tens"}, 32'(Tens), 32'(exp_seg[(value / 10) % 10]));
    check({name, ".ones"}, 32'(Ones), 32'(exp_seg[value % 10]));
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
    cur_edge++;
  endtask

  task automatic run_to(input int target);
    while (cur_edge < target) step();
  endtask

  task automatic do_reset(input int cycles);
    Reset = 1'b1;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    Reset    = 1'b0;
    cur_edge = 0;
  endtask

  vec_t vecs [11];

  initial begin
    Reset = 1'b1;

    vecs[0]  = '{1,   1,  "lw_r1"};
    vecs[1]  = '{2,   3,  "lw_r2"};
    vecs[2]  = '{3,   4,  "add_r3"};
    vecs[3]  = '{4,   5,  "add_r1"};
    vecs[4]  = '{5,   5,  "jump_hold"};
    vecs[5]  = '{6,   9,  "loop_k1"};
    vecs[6]  = '{7,   9,  "jump_hold2"};
    vecs[7]  = '{8,   13, "loop_k2"};
    vecs[8]  = '{20,  37, "loop_k8"};
    vecs[9]  = '{128, 53, "loop_k62_r253"};
    vecs[10] = '{130, 1,  "wrap_r1"};

    // Reset held for five cycles: display 00 and PC parked at 0 throughout.
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_disp($sformatf("reset_hold%0d", c), 0);
      check($sformatf("reset_pc%0d", c), 32'(dut.pc), 32'd0);
    end
    Reset    = 1'b0;
    cur_edge = 0;

    // Main program trace, including the 253 -> 1 wrap of R1.
    foreach (vecs[i]) begin
      run_to(vecs[i].edge_no);
      check_disp(vecs[i].name, vecs[i].shown);
    end

    // Mid-loop reset at display 37: one reset edge gives 00, then replay.
    do_reset(1);
    run_to(20);
    check_disp("pre_midreset", 37);
    Reset = 1'b1;
    @(posedge clk);
    #1;
    check_disp("midreset", 0);
    check("midreset_pc", 32'(dut.pc), 32'd0);
    Reset    = 1'b0;
    cur_edge = 0;
    for (int e = 1; e <= 4; e++) begin
      int seq [4];
      seq = '{1, 3, 4, 5};
      step();
      check_disp($sformatf("replay_e%0d", e), seq[e-1]);
    end

    // Alternate program: after R1=1, R2=3, R3=4 (display 04), store R2 to
    // RAM[R1+1]=RAM[2] (display must hold 04), then load RAM[2] into R0:
    // 3 proves the store landed (the reset image there is 2).
    do_reset(1);
    run_to(3);
    check_disp("alt_pre", 4);
    force dut.instr = 8'h99;   // SW R2,[R1+1]
    step();
    check_disp("alt_sw_keeps_disp", 4);
    force dut.instr = 8'h51;   // LW R0,[R1+1]
    step();
    check_disp("alt_lw_readback", 3);
    release dut.instr;
    step();                    // PC is 5: the park loop leaves display alone
    check_disp("alt_park", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
